// File: rtl/rggen_bit_field_w01trg_queued.sv
// rggen_bit_field_w01trg_queued
//   Write-0/1 trigger bit field with a per-channel pending-request queue.
//   Each bit is an independent channel: a matching write enqueues a request,
//   an ack consumes one, and the channel requests while its count is nonzero.
//   Optional feature macro: RGGEN_BIT_FIELD_W01TRG_OVERFLOW_EN
//     defined   -> sticky per-channel overflow flag set on a dropped fire
//     undefined -> o_overflow tied low, i_overflow_clear ignored
module rggen_bit_field_w01trg_queued #(
    parameter logic TRIGGER_VALUE = 1'b0,
    parameter int   WIDTH         = 8,
    parameter int   COUNTER_WIDTH = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_bit_field_valid,
    input  logic [WIDTH-1:0] i_bit_field_read_mask,
    input  logic [WIDTH-1:0] i_bit_field_write_mask,
    input  logic [WIDTH-1:0] i_bit_field_write_data,
    output logic [WIDTH-1:0] o_bit_field_read_data,
    output logic [WIDTH-1:0] o_bit_field_value,
    output logic [WIDTH-1:0] o_trigger,
    input  logic [WIDTH-1:0] i_trigger_ack,
    output logic [WIDTH-1:0] o_overflow,
    input  logic [WIDTH-1:0] i_overflow_clear
);

    localparam logic [COUNTER_WIDTH-1:0] MAX_COUNT = '1;
    localparam logic [COUNTER_WIDTH-1:0] ONE       = COUNTER_WIDTH'(1);

    logic [COUNTER_WIDTH-1:0] count [WIDTH];
    logic [WIDTH-1:0]         fire;
    logic [WIDTH-1:0]         consume;
    logic [WIDTH-1:0]         drop;
    logic [WIDTH-1:0]         pending;

    // Per-channel fire/consume/drop decode and pending flags from registered counts.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        fire    = '0;
        consume = '0;
        drop    = '0;
        pending = '0;
        for (int i = 0; i < WIDTH; i++) begin
            fire[i]    = i_bit_field_valid && i_bit_field_write_mask[i]
                         && (i_bit_field_write_data[i] == TRIGGER_VALUE);
            pending[i] = (count[i] != '0);
            consume[i] = i_trigger_ack[i] && pending[i];
            drop[i]    = fire[i] && !consume[i] && (count[i] == MAX_COUNT);
        end
    end

    // Pending counters: fire increments (saturating), consume decrements, both together hold.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            // NOTE: the count array is state that drives outputs, so every entry is reset, unlike a data-only RAM.
            for (int i = 0; i < WIDTH; i++) begin
                count[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
                if (fire[i] && !consume[i] && (count[i] != MAX_COUNT)) begin
                    count[i] <= count[i] + ONE;
                end else if (consume[i] && !fire[i]) begin
                    count[i] <= count[i] - ONE;
                end
            end
        end
    end

    assign o_trigger             = pending;
    assign o_bit_field_read_data = pending;
    assign o_bit_field_value     = pending;

`ifdef RGGEN_BIT_FIELD_W01TRG_OVERFLOW_EN
    logic [WIDTH-1:0] overflow;

    // Sticky overflow: a dropped fire sets the flag and wins over a same-cycle clear.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            overflow <= '0;
        end else begin
            overflow <= drop | (overflow & ~i_overflow_clear);
        end
    end

    assign o_overflow = overflow;
`else
    assign o_overflow = '0;
`endif

    // The read mask never affects state; in the default build the clear and drop are unused too.
    logic unused_inputs;
    assign unused_inputs = ^{i_bit_field_read_mask, i_overflow_clear, drop};

endmodule

// File: tb/tb_rggen_bit_field_w01trg_queued.sv
// tb_rggen_bit_field_w01trg_queued
//   Two instances (write-1 and write-0 trigger, WIDTH=4, COUNTER_WIDTH=2)
//   driven by the same directed vectors and checked every cycle against a
//   queue-count model, plus hand-computed literal expectations.
module tb_rggen_bit_field_w01trg_queued;

    localparam int W   = 4;
    localparam int MAX = 3;
`ifdef RGGEN_BIT_FIELD_W01TRG_OVERFLOW_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic         i_clk = 1'b0;
    logic         i_rst;
    logic         valid;
    logic [W-1:0] rmask, wmask, wdata, ack, oclr;
    logic [W-1:0] rd0, val0, trig0, ovf0;
    logic [W-1:0] rd1, val1, trig1, ovf1;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    // model: [0] = write-0 trigger instance, [1] = write-1 trigger instance
    int cnt [2][W];
    bit ovf [2][W];

    always #5 i_clk = ~i_clk;

    rggen_bit_field_w01trg_queued #(.TRIGGER_VALUE(1'b0), .WIDTH(W), .COUNTER_WIDTH(2)) u_dut0 (
        .i_clk(i_clk), .i_rst(i_rst), .i_bit_field_valid(valid),
        .i_bit_field_read_mask(rmask), .i_bit_field_write_mask(wmask),
        .i_bit_field_write_data(wdata), .o_bit_field_read_data(rd0),
        .o_bit_field_value(val0), .o_trigger(trig0), .i_trigger_ack(ack),
        .o_overflow(ovf0), .i_overflow_clear(oclr)
    );

    rggen_bit_field_w01trg_queued #(.TRIGGER_VALUE(1'b1), .WIDTH(W), .COUNTER_WIDTH(2)) u_dut1 (
        .i_clk(i_clk), .i_rst(i_rst), .i_bit_field_valid(valid),
        .i_bit_field_read_mask(rmask), .i_bit_field_write_mask(wmask),
        .i_bit_field_write_data(wdata), .o_bit_field_read_data(rd1),
        .o_bit_field_value(val1), .o_trigger(trig1), .i_trigger_ack(ack),
        .o_overflow(ovf1), .i_overflow_clear(oclr)
    );

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b required=%b t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] exp_pend(input int d);
        logic [W-1:0] v = '0;
        for (int i = 0; i < W; i++) v[i] = (cnt[d][i] != 0);
        return v;
    endfunction

    function automatic logic [W-1:0] exp_ovf(input int d);
        logic [W-1:0] v = '0;
        for (int i = 0; i < W; i++) v[i] = ovf[d][i];
        return v;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < W; i++) begin
                cnt[d][i] = 0;
                ovf[d][i] = 1'b0;
            end
    endtask

    // Apply one clock edge's worth of queue rules using the inputs held across it.
    task automatic model_update();
        if (i_rst) begin
            model_reset();
            return;
        end
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < W; i++) begin
                bit f, c;
                f = valid && wmask[i] && (wdata[i] == d[0]);
                c = ack[i] && (cnt[d][i] > 0);
                if (OVF_EN && oclr[i]) ovf[d][i] = 1'b0;
                if (f && !c) begin
                    if (cnt[d][i] < MAX) cnt[d][i]++;
                    else if (OVF_EN) ovf[d][i] = 1'b1;
                end else if (c && !f) begin
                    cnt[d][i]--;
                end
            end
    endtask

    task automatic step();
        @(posedge i_clk);
        model_update();
        #1;
    endtask

    task automatic wr(input logic [W-1:0] d, input logic [W-1:0] m, input int n);
        for (int k = 0; k < n; k++) begin
            valid = 1'b1; wdata = d; wmask = m;
            step();
        end
        valid = 1'b0; wdata = '0; wmask = '0;
    endtask

    task automatic do_ack(input logic [W-1:0] m, input int n);
        ack = m;
        for (int k = 0; k < n; k++) step();
        ack = '0;
    endtask

    // Every-cycle comparison of both instances against the model.
    always @(negedge i_clk) begin
        if (cmp_en) begin
            check("m_trig0", trig0, exp_pend(0));
            check("m_rd0",   rd0,   exp_pend(0));
            check("m_val0",  val0,  exp_pend(0));
            check("m_ovf0",  ovf0,  exp_ovf(0));
            check("m_trig1", trig1, exp_pend(1));
            check("m_rd1",   rd1,   exp_pend(1));
            check("m_val1",  val1,  exp_pend(1));
            check("m_ovf1",  ovf1,  exp_ovf(1));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [W-1:0] ovf_exp;
        i_rst = 1'b1; valid = 1'b0; rmask = '0; wmask = '0; wdata = '0; ack = '0; oclr = '0;
        model_reset();
        #2;
        check("rst_trig1", trig1, 4'b0000);
        check("rst_ovf1",  ovf1,  4'b0000);
        repeat (2) @(posedge i_clk);
        #3 i_rst = 1'b0;
        cmp_en = 1'b1;

        // write-1 / write-0 with full mask
        wr(4'b0101, 4'b1111, 1);
        check("w1_trig1", trig1, 4'b0101);
        check("w1_trig0", trig0, 4'b1010);
        step(); step();
        check("w1_hold1", trig1, 4'b0101);
        do_ack(4'b1111, 1);
        check("w1_drain1", trig1, 4'b0000);
        check("w1_drain0", trig0, 4'b0000);

        // partial mask
        wr(4'b0101, 4'b0011, 1);
        check("pm_trig0", trig0, 4'b0010);
        check("pm_trig1", trig1, 4'b0001);
        do_ack(4'b1111, 1);

        // queue depth 3 then 4 acks, the 4th ignored
        wr(4'b0001, 4'b0001, 3);
        do_ack(4'b0001, 1); check("q_ack1", trig1, 4'b0001);
        ack = 4'b0001; step(); check("q_ack2", trig1, 4'b0001);
        step(); check("q_ack3", trig1, 4'b0000);
        step(); check("q_ack4", trig1, 4'b0000);
        ack = '0;
        wr(4'b0001, 4'b0001, 1);
        check("q_nounder", trig1, 4'b0001);
        do_ack(4'b0001, 1);
        check("q_nounder2", trig1, 4'b0000);

        // saturation and overflow
        ovf_exp = OVF_EN ? 4'b0001 : 4'b0000;
        wr(4'b0001, 4'b0001, 4);
        check("ov_trig", trig1, 4'b0001);
        check("ov_set", ovf1, ovf_exp);
        oclr = 4'b0001; step(); oclr = '0;
        check("ov_clr", ovf1, 4'b0000);
        oclr = 4'b0001; wr(4'b0001, 4'b0001, 1); oclr = '0;
        check("ov_clr_vs_set", ovf1, ovf_exp);
        oclr = 4'b0001; step(); oclr = '0;
        check("ov_clr2", ovf1, 4'b0000);
        do_ack(4'b0001, 2); check("ov_drain2", trig1, 4'b0001);
        do_ack(4'b0001, 1); check("ov_drain3", trig1, 4'b0000);

        // fire and ack together at MAX
        wr(4'b0100, 4'b0100, 3);
        ack = 4'b0100; wr(4'b0100, 4'b0100, 1); ack = '0;
        check("fa_ovf", ovf1, 4'b0000);
        do_ack(4'b0100, 2); check("fa_two", trig1, 4'b0100);
        do_ack(4'b0100, 1); check("fa_three", trig1, 4'b0000);

        // read access changes nothing
        valid = 1'b1; rmask = 4'b1111; wdata = 4'b1111; wmask = '0; step();
        valid = 1'b0; rmask = '0; wdata = '0;
        check("rd_trig1", trig1, 4'b0000);
        check("rd_trig0", trig0, 4'b0000);

        // mid-operation asynchronous reset
        wr(4'b1111, 4'b1111, 4);
        wr(4'b0000, 4'b1111, 2);
        check("pre_rst1", trig1, 4'b1111);
        check("pre_rst0", trig0, 4'b1111);
        check("pre_rst_ovf", ovf1, OVF_EN ? 4'b1111 : 4'b0000);
        #3 i_rst = 1'b1;
        model_reset();
        #1;
        check("ar_trig1", trig1, 4'b0000);
        check("ar_trig0", trig0, 4'b0000);
        check("ar_rd1",   rd1,   4'b0000);
        check("ar_val0",  val0,  4'b0000);
        check("ar_ovf1",  ovf1,  4'b0000);
        step(); step();
        #3 i_rst = 1'b0;
        step();
        check("post_rst1", trig1, 4'b0000);
        check("post_rst0", trig0, 4'b0000);
        wr(4'b0010, 4'b0010, 1);
        check("post_fire1", trig1, 4'b0010);
        step(); step();

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
